// File: rtl/blk2s_post_tree.sv
// Folds the OUTPUT_SIZE-byte PRF output into a PTR_W-bit buffer pointer
// (byte-sum or byte-XOR per transaction) through a 3-stage valid/ready pipeline.
module blk2s_post_tree #(
    parameter int OUTPUT_SIZE = 32,
    parameter int LEAF        = 8,
    parameter int PTR_W       = 8,
    parameter int BUF_DEPTH   = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [OUTPUT_SIZE*8-1:0] prf_output,
    input  logic                     in_mode,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [PTR_W-1:0]         buf_ptr,
    output logic                     busy
);

    localparam int NLEAF  = OUTPUT_SIZE / LEAF;
    localparam int LEAF_W = 8 + $clog2(LEAF);
    localparam int TOT_W  = 8 + $clog2(OUTPUT_SIZE);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(BUF_DEPTH);

    logic v0_reg, v1_reg, v2_reg;
    logic adv0, adv1, adv2;

    logic [NLEAF-1:0][LEAF_W-1:0] leaf_next;
    logic [NLEAF-1:0][LEAF_W-1:0] leaf_reg;
    logic                         mode0_reg;

    logic [TOT_W-1:0] tot_sum, tot_next, tot_reg;
    logic [7:0]       tot_xor;

    logic [PTR_W-1:0] t_val;
    logic [PTR_W:0]   t_wide;
    logic [PTR_W-1:0] ptr_next, ptr_reg;

    // A stage may load whenever it is empty or everything ahead of it moves.
    assign adv2   = ~v2_reg | out_rdy;
    assign adv1   = ~v1_reg | adv2;
    assign adv0   = ~v0_reg | adv1;
    assign in_rdy = adv0;

    assign out_vld = v2_reg;
    assign buf_ptr = ptr_reg;
    assign busy    = v0_reg | v1_reg | v2_reg;

    // Stage 0: one reducer per LEAF-byte group.
    generate
        for (genvar gi = 0; gi < NLEAF; gi++) begin : g_leaf
            logic [LEAF_W-1:0] sum_c;
            logic [7:0]        xor_c;

            always_comb begin
                sum_c = '0;
                xor_c = '0;
                for (int b = 0; b < LEAF; b++) begin
                    sum_c = sum_c + LEAF_W'(prf_output[(gi*LEAF + b)*8 +: 8]);
                    xor_c = xor_c ^ prf_output[(gi*LEAF + b)*8 +: 8];
                end
            end

            assign leaf_next[gi] = in_mode ? LEAF_W'(xor_c) : sum_c;
        end
    endgenerate

    // Stage 1: combine the leaves; XOR leaves only ever occupy the low byte.
    always_comb begin
        tot_sum = '0;
        tot_xor = '0;
        for (int i = 0; i < NLEAF; i++) begin
            tot_sum = tot_sum + TOT_W'(leaf_reg[i]);
            tot_xor = tot_xor ^ leaf_reg[i][7:0];
        end
        tot_next = mode0_reg ? TOT_W'(tot_xor) : tot_sum;
    end

    // Stage 2: truncate (or zero-extend) to PTR_W, then one conditional wrap.
    always_comb begin
        t_val    = PTR_W'(tot_reg);
        t_wide   = {1'b0, t_val};
        ptr_next = t_val;
        if (t_wide >= DEPTH_C) begin
            ptr_next = PTR_W'(t_wide - DEPTH_C);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_reg <= 1'b0;
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
        end else begin
            if (adv0) v0_reg <= in_vld;
            if (adv1) v1_reg <= v0_reg;
            if (adv2) v2_reg <= v1_reg;
        end
    end

    // Data registers carry no reset; their contents only matter under a valid.
    always_ff @(posedge clk) begin
        if (adv0) begin
            leaf_reg  <= leaf_next;
            mode0_reg <= in_mode;
        end
        if (adv1) begin
            tot_reg <= tot_next;
        end
        if (adv2) begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: tb/tb_blk2s_post_tree.sv
// Scoreboard bench for blk2s_post_tree: two instances (BUF_DEPTH 256 and 200)
// share stimulus; a negedge monitor checks handshakes, latency and pointer values.
module tb_blk2s_post_tree;

    localparam int OS    = 32;
    localparam int PTR_W = 8;

    typedef struct {
        int t;
        int c;
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            in_vld;
    logic            in_mode;
    logic            out_rdy = 1'b1;
    logic [OS*8-1:0] prf_output;

    logic             in_rdy_a, in_rdy_b, out_vld_a, out_vld_b, busy_a, busy_b;
    logic [PTR_W-1:0] ptr_a, ptr_b;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    acc_cnt  = 0;
    int    out_cnt  = 0;
    item_t exp_q[$];
    bit    rdy_rand  = 1'b0;
    bit    rdy_force = 1'b1;
    bit    prev_stall = 1'b0;
    logic [PTR_W-1:0] prev_ptr;

    blk2s_post_tree u_dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy_a),
        .prf_output(prf_output), .in_mode(in_mode), .out_vld(out_vld_a),
        .out_rdy(out_rdy), .buf_ptr(ptr_a), .busy(busy_a)
    );

    blk2s_post_tree #(.BUF_DEPTH(200)) u_dut200 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy_b),
        .prf_output(prf_output), .in_mode(in_mode), .out_vld(out_vld_b),
        .out_rdy(out_rdy), .buf_ptr(ptr_b), .busy(busy_b)
    );

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        out_rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: whole-vector byte sum mod 2^PTR_W, or whole-vector byte XOR.
    function automatic int ref_t(input logic [OS*8-1:0] d, input bit m);
        int s = 0;
        int x = 0;
        for (int k = 0; k < OS; k++) begin
            s += int'(d[8*k +: 8]);
            x ^= int'(d[8*k +: 8]);
        end
        return m ? x : (s % (1 << PTR_W));
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("out_vld", out_vld_a,
                  (exp_q.size() > 0) && (cyc - exp_q[0].c >= 3));
            check("busy", busy_a, exp_q.size() > 0);
            check("in_rdy", in_rdy_a, (exp_q.size() < 3) || out_rdy);
            if (prev_stall) check("hold_ptr", ptr_a, prev_ptr);
            if (out_vld_a && out_rdy) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out: got ptr %0d, expected no output (cycle %0d)",
                             ptr_a, cyc);
                end else begin
                    item_t it;
                    it = exp_q.pop_front();
                    out_cnt++;
                    $display("txn %0d: t=%0d ptr256=%0d ptr200=%0d", out_cnt, it.t, ptr_a, ptr_b);
                    check("ptr_d256", ptr_a, it.t % 256);
                    check("ptr_d200", ptr_b, it.t % 200);
                end
            end
            if (in_vld && in_rdy_a) begin
                item_t ni;
                ni.t = ref_t(prf_output, in_mode);
                ni.c = cyc;
                exp_q.push_back(ni);
                acc_cnt++;
            end
            prev_stall = out_vld_a && !out_rdy;
            prev_ptr   = ptr_a;
        end
    end

    task automatic send(input logic [OS*8-1:0] d, input bit m);
        int w = 0;
        bit acc = 1'b0;
        in_vld     = 1'b1;
        prf_output = d;
        in_mode    = m;
        do begin
            @(negedge clk);
            acc = in_rdy_a;
            @(posedge clk);
            #1;
            w++;
        end while (!acc && w < 200);
        check("send_accept", acc, 1);
    endtask

    task automatic idle(input int n);
        in_vld = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int w = 0;
        in_vld = 1'b0;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [OS*8-1:0] fill(input logic [7:0] v);
        logic [OS*8-1:0] d;
        for (int k = 0; k < OS; k++) d[8*k +: 8] = v;
        return d;
    endfunction

    function automatic logic [OS*8-1:0] ramp();
        logic [OS*8-1:0] d;
        for (int k = 0; k < OS; k++) d[8*k +: 8] = 8'(k);
        return d;
    endfunction

    function automatic logic [OS*8-1:0] rnd_data();
        logic [OS*8-1:0] d;
        for (int k = 0; k < OS; k++) d[8*k +: 8] = 8'($urandom_range(0, 255));
        return d;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [OS*8-1:0] d;
        int base;
        int t0;

        rst        = 1'b1;
        in_vld     = 1'b0;
        in_mode    = 1'b0;
        prf_output = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_vld", out_vld_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_in_rdy", in_rdy_a, 1);
        @(posedge clk);
        #1;

        // All 0xFF in sum mode: 8160 -> 0xE0 (224, or 24 with depth 200), 3 cycles later.
        send(fill(8'hFF), 1'b0);
        in_vld = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("latency", out_vld_a, k == 3);
        end
        @(posedge clk);
        #1;

        send(ramp(), 1'b0);
        send(ramp(), 1'b1);
        d = '0;
        d[7:0] = 8'hA5;
        send(d, 1'b1);
        drain();

        // Backpressure: 5 beats, alternating modes, with out_rdy low for 6 cycles.
        rdy_force = 1'b0;
        @(posedge clk);
        #1;
        base = acc_cnt;
        fork
            begin
                for (int n = 1; n <= 5; n++) begin
                    d = '0;
                    if (n % 2 == 0) begin
                        d[7:0]  = 8'(n | 16);
                        d[15:8] = 8'h10;
                        send(d, 1'b1);
                    end else begin
                        d[7:0] = 8'(n);
                        send(d, 1'b0);
                    end
                end
                in_vld = 1'b0;
            end
            begin
                repeat (5) @(negedge clk);
                check("held_accepts", acc_cnt - base, 3);
                check("held_in_rdy", in_rdy_a, 0);
                rdy_force = 1'b1;
            end
        join
        drain();

        // Continuous streaming: one accept per cycle.
        t0 = cyc;
        for (int i = 0; i < 20; i++) send(rnd_data(), 1'(i % 3 == 0));
        check("stream_cycles", cyc - t0, 20);
        drain();

        // Reset with two transactions in flight.
        rdy_force = 1'b0;
        @(posedge clk);
        #1;
        send(rnd_data(), 1'b0);
        send(rnd_data(), 1'b1);
        in_vld = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        rdy_force = 1'b1;
        @(negedge clk);
        check("mid_rst_out_vld", out_vld_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_in_rdy", in_rdy_a, 1);
        @(posedge clk);
        #1;
        idle(10);

        // Random traffic with random backpressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       d = fill(8'hFF);
                1:       d = '0;
                default: d = rnd_data();
            endcase
            send(d, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        in_vld   = 1'b0;
        rdy_rand = 1'b0;
        @(posedge clk);
        #1;
        drain();
        check("total_out", out_cnt, acc_cnt - 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
